// File: rtl/chip_tester_pkg.sv
// chip_tester_pkg: shared types and default constants for the table-driven
// DIP logic-chip tester.
//   tester_state_e : run sequencer states
//   test_vec_t     : one table entry {drive, oe, expected, care}, CT_NUM_PINS wide
//   CT_*           : default parameter values for chip_vector_tester
package chip_tester_pkg;

  localparam int unsigned CT_NUM_PINS     = 16;
  localparam int unsigned CT_NUM_VEC      = 32;
  localparam int unsigned CT_SETTLE_TICKS = 2;
  localparam int unsigned CT_SYNC_STAGES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SYNC,
    ST_CMP,
    ST_FINISH
  } tester_state_e;

  typedef struct packed {
    logic [CT_NUM_PINS-1:0] drive;
    logic [CT_NUM_PINS-1:0] oe;
    logic [CT_NUM_PINS-1:0] expected;
    logic [CT_NUM_PINS-1:0] care;
  } test_vec_t;

endpackage

// File: rtl/chip_pin_sync.sv
// chip_pin_sync: STAGES-deep flop synchroniser for the asynchronous socket pins.
//   Clk   in  system clock
//   Reset in  asynchronous active-low reset
//   d     in  WIDTH asynchronous pin values
//   q     out WIDTH synchronised pin values (STAGES Clk cycles of latency)
module chip_pin_sync #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/chip_vector_tester.sv
// chip_vector_tester: table-driven DIP logic-chip tester engine.
// Replays a loaded vector table on the socket pins and compares sensed chip
// outputs against expected values (only undriven, cared-for pins are compared).
// Optional feature macro: CHIP_TESTER_FAILCNT_EN (adds fail_count, run does
// not stop at the first failing vector).
// Ports:
//   Clk, Reset (async active-low), step_tick (1-Clk settle strobe)
//   vec_we/vec_addr/vec_drive/vec_oe/vec_expect/vec_care : table write (idle only)
//   num_vec, start : run length (clamped to NUM_VEC) and run start pulse
//   pin_in         : asynchronous sensed pins
//   pin_out/pin_oe : socket drive values and tri-state enables
//   busy, done, pass, fail_index, fail_mask [, fail_count] : run status/result
module chip_vector_tester
  import chip_tester_pkg::*;
#(
  parameter int unsigned NUM_PINS     = CT_NUM_PINS,  // must equal CT_NUM_PINS (table entry width)
  parameter int unsigned NUM_VEC      = CT_NUM_VEC,
  parameter int unsigned SETTLE_TICKS = CT_SETTLE_TICKS,
  parameter int unsigned SYNC_STAGES  = CT_SYNC_STAGES
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         step_tick,
  input  logic                         vec_we,
  input  logic [$clog2(NUM_VEC)-1:0]   vec_addr,
  input  logic [NUM_PINS-1:0]          vec_drive,
  input  logic [NUM_PINS-1:0]          vec_oe,
  input  logic [NUM_PINS-1:0]          vec_expect,
  input  logic [NUM_PINS-1:0]          vec_care,
  input  logic [$clog2(NUM_VEC+1)-1:0] num_vec,
  input  logic                         start,
  input  logic [NUM_PINS-1:0]          pin_in,
  output logic [NUM_PINS-1:0]          pin_out,
  output logic [NUM_PINS-1:0]          pin_oe,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [$clog2(NUM_VEC)-1:0]   fail_index,
  output logic [NUM_PINS-1:0]          fail_mask
`ifdef CHIP_TESTER_FAILCNT_EN
  ,
  output logic [$clog2(NUM_VEC+1)-1:0] fail_count
`endif
);

  localparam int unsigned IW = $clog2(NUM_VEC);
  localparam int unsigned CW = $clog2(NUM_VEC+1);
  localparam int unsigned SW = $clog2(SETTLE_TICKS+1);
  localparam int unsigned YW = $clog2(SYNC_STAGES+1);

  tester_state_e state, state_d;

  test_vec_t     vec_table [NUM_VEC];
  test_vec_t     cur;
  logic [IW-1:0] idx;
  logic [CW-1:0] n_lat;
  logic [CW-1:0] n_start;
  logic [SW-1:0] settle_cnt;
  logic [YW-1:0] sync_cnt;
  logic [NUM_PINS-1:0] sync_pin;
  logic [NUM_PINS-1:0] mism;
  logic          last_vec;

  chip_pin_sync #(
    .WIDTH  (NUM_PINS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (pin_in),
    .q     (sync_pin)
  );

  // Table is frozen while a run is in progress; contents are not reset.
  always_ff @(posedge Clk) begin
    if (vec_we && !busy) begin
      vec_table[vec_addr] <= '{drive: vec_drive, oe: vec_oe,
                               expected: vec_expect, care: vec_care};
    end
  end

  assign n_start  = (num_vec > CW'(NUM_VEC)) ? CW'(NUM_VEC) : num_vec;
  assign cur      = vec_table[idx];
  assign mism     = (sync_pin ^ cur.expected) & cur.care & ~cur.oe;
  assign last_vec = (CW'(idx) + CW'(1)) == n_lat;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (start) state_d = (n_start == '0) ? ST_FINISH : ST_APPLY;
      ST_APPLY:  state_d = ST_SETTLE;
      ST_SETTLE: if (step_tick && settle_cnt == SW'(1)) state_d = ST_SYNC;
      ST_SYNC:   if (sync_cnt == YW'(1)) state_d = ST_CMP;
      ST_CMP: begin
`ifdef CHIP_TESTER_FAILCNT_EN
        state_d = last_vec ? ST_FINISH : ST_APPLY;
`else
        state_d = (last_vec || mism != '0) ? ST_FINISH : ST_APPLY;
`endif
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pin_out    <= '0;
      pin_oe     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_index <= '0;
      fail_mask  <= '0;
      idx        <= '0;
      n_lat      <= '0;
      settle_cnt <= '0;
      sync_cnt   <= '0;
`ifdef CHIP_TESTER_FAILCNT_EN
      fail_count <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_lat      <= n_start;
            idx        <= '0;
            pass       <= 1'b1;
            fail_index <= '0;
            fail_mask  <= '0;
            busy       <= 1'b1;
`ifdef CHIP_TESTER_FAILCNT_EN
            fail_count <= '0;
`endif
          end
        end
        ST_APPLY: begin
          pin_out    <= cur.drive;
          pin_oe     <= cur.oe;
          settle_cnt <= SW'(SETTLE_TICKS);
        end
        ST_SETTLE: begin
          if (step_tick) begin
            settle_cnt <= settle_cnt - SW'(1);
            if (settle_cnt == SW'(1)) sync_cnt <= YW'(SYNC_STAGES);
          end
        end
        ST_SYNC: sync_cnt <= sync_cnt - YW'(1);
        ST_CMP: begin
          if (mism != '0) begin
            // Only the first failing vector is recorded; pass doubles as the
            // "no failure yet" flag.
            if (pass) begin
              pass       <= 1'b0;
              fail_index <= idx;
              fail_mask  <= mism;
            end
`ifdef CHIP_TESTER_FAILCNT_EN
            fail_count <= fail_count + CW'(1);
`endif
          end
          if (!last_vec) idx <= idx + IW'(1);
        end
        ST_FINISH: begin
          pin_oe <= '0;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
